// File: rtl/mux32_rr_sched_if.sv
// Requester-bank / mux / consumer bundle for the round-robin mux scheduler.
// master = scheduler side, slave = requesters, mux tree and consumer.
interface mux32_rr_sched_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic [31:0]      req;
  logic [WIDTH-1:0] mux_in;
  logic             out_ready;
  logic [4:0]       sel;
  logic [31:0]      ack;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [4:0]       out_src;

  modport master (
    input  req, mux_in, out_ready,
    output sel, ack, out_valid, out_data, out_src
  );

  modport slave (
    output req, mux_in, out_ready,
    input  sel, ack, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux32_rr_sched.sv
// Round-robin scheduler sharing a 32:1 mux among 32 requesters; captures the
// selected word and offers it downstream over a valid/ready handshake.
module mux32_rr_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  mux32_rr_sched_if.master  bus,
  output logic              busy
);
  localparam int unsigned N_REQ = 32;
  localparam int unsigned SEL_W = 5;

  typedef enum logic [1:0] {IDLE, SELECT, HOLD} state_t;

  state_t             state, state_d;
  logic [SEL_W-1:0]   ptr, ptr_d;
  logic [SEL_W-1:0]   win;
  logic               found;
  logic [SEL_W-1:0]   sel_d, src_d;
  logic [N_REQ-1:0]   ack_d;
  logic               valid_d, busy_d;
  logic [WIDTH-1:0]   data_d;

  // First pending request at or after ptr, wrapping modulo 32
  always_comb begin
    logic [SEL_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    sel_d   = bus.sel;
    ack_d   = '0;
    valid_d = bus.out_valid;
    data_d  = bus.out_data;
    src_d   = bus.out_src;

    unique case (state)
      IDLE: begin
        valid_d = 1'b0;
        if (found) begin
          state_d = SELECT;
          sel_d   = win;
          ack_d   = N_REQ'(1) << win;
          ptr_d   = win + SEL_W'(1);
        end
      end
      SELECT: begin
        state_d = HOLD;
        valid_d = 1'b1;
        data_d  = bus.mux_in;
        src_d   = bus.sel;
      end
      HOLD: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          if (found) begin
            state_d = SELECT;
            sel_d   = win;
            ack_d   = N_REQ'(1) << win;
            ptr_d   = win + SEL_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.sel       <= '0;
      bus.ack       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      ptr           <= ptr_d;
      bus.sel       <= sel_d;
      bus.ack       <= ack_d;
      bus.out_valid <= valid_d;
      bus.out_data  <= data_d;
      bus.out_src   <= src_d;
      busy          <= busy_d;
    end
  end
endmodule
